hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller for the five-stage MIPS core; it drives the select inputs of the Execute-stage operand forwarding muxes. Encodings: 00 selects the register-file value, 01 selects ResultW, 10 selects ALUOutM. It also generates the Fetch/Decode stall and the Decode/Execute flush. A small state machine tracks an in-flight multi-cycle mult/div so that HI/LO reads are interlocked. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
- MD_LATENCY, 4, cycles from mult/div issue in Execute until HI/LO is valid (range 2..15)
- CNT_W, 16, width of the stall-cycle counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- rsD, rtD  in  5 each  source register numbers of the instruction in Decode
- rsE, rtE  in  5 each  source register numbers of the instruction in Execute
- writeRegE, writeRegM, writeRegW  in  5 each  destination registers in Execute, Memory and Writeback
- regWriteE, regWriteM, regWriteW  in  1 each  register-write enables per stage
- memToRegE, memToRegM  in  1 each  the instruction in that stage is a load
- branchD  in  1  Decode holds beq/bne
- pcSrcD, jumpD  in  1 each  taken branch or jump resolved in Decode
- mdOpD  in  1  Decode holds mult/multu/div/divu
- mfHiLoD  in  1  Decode holds mfhi/mflo
- mdStartE  in  1  a mult/div is in Execute this cycle
- forwardAE, forwardBE  out  2 each  Execute forwarding mux selects
- forwardAD, forwardBD  out  1 each  Decode branch-comparator forwarding selects (1 selects ALUOutM)
- stallF, stallD  out  1 each  hold the PC and the IF/ID register
- flushD, flushE  out  1 each  clear the IF/ID and ID/EX registers
- mdBusy  out  1  a mult/div is in flight
- stallCount  out  CNT_W  number of cycles in which stallD was asserted, saturating

## Operation
- Forwarding for forwardAE (forwardBE is identical with rtE in place of rsE):
  - 10 if regWriteM && writeRegM!=0 && writeRegM==rsE.
  - Otherwise 01 if regWriteW && writeRegW!=0 && writeRegW==rsE.
  - Otherwise 00.
  - The Memory stage has priority over Writeback. Register $0 is never forwarded. The value 11 is never driven.
- loadStall = memToRegE && regWriteE && writeRegE!=0 && (writeRegE==rsD || writeRegE==rtD).
- branchStall = branchD && (E-match || M-match):
  - E-match: regWriteE && writeRegE!=0 && writeRegE equals rsD or rtD.
  - M-match: the same test on the M-stage signals, qualified as defined under Configuration.
- mdStall = mdBusy && (mfHiLoD || mdOpD).
- stall = loadStall | branchStall | mdStall. stallF, stallD and flushE all equal stall.
- flushD = (pcSrcD | jumpD) & ~stall.
- Mult/div state machine, states IDLE and BUSY, with a 4-bit down-counter mdCnt:
  - In IDLE, mdStartE loads mdCnt = MD_LATENCY-1 and moves to BUSY.
  - In BUSY, mdCnt decrements each cycle. When mdCnt reaches 0 the state returns to IDLE on the next edge.
  - mdStartE while in BUSY reloads the counter and stays in BUSY. The interlock should prevent this; if it occurs, this is the required recovery.
  - mdBusy = (state==BUSY).
- stallCount increments on every edge where stallD=1 and saturates at all-ones.

## Timing
- forward*, stall*, flush* are combinational from the current inputs and the registered state. There are no registered outputs except mdBusy and stallCount.
- A load-use dependency stalls for exactly 1 cycle, then resolves through forwardXE=01.
- mult/div issue at edge N: mdBusy is high from N to N+MD_LATENCY-1. An mfhi waiting in Decode is released in the cycle after mdBusy falls.
- Reset (asynchronous, while rst_n=0): state=IDLE, mdCnt=0, mdBusy=0, stallCount=0. During reset the combinational outputs still follow the inputs.
- Reset asserted mid-mult/div abandons the operation immediately.
- Simultaneous stall and taken branch: the stall wins and flushD=0.

## Configuration
- HAZARD_BRANCH_FWD_EN defined (Decode-stage branch forwarding):
  - forwardAD = branchD-independent match of rsD against writeRegM with regWriteM && writeRegM!=0. forwardBD is the same with rtD.
  - The M-match term of branchStall applies only when memToRegM=1.
- HAZARD_BRANCH_FWD_EN undefined:
  - forwardAD and forwardBD are tied to 0.
  - The M-match term of branchStall applies to any M-stage writer.

## Structure
- Shared package mips_pkg holds:
  - the FWD_RF=2'b00, FWD_WB=2'b01 and FWD_MEM=2'b10 constants, which the forwarding mux instantiation uses as well;
  - the md_state_t enum (MD_IDLE, MD_BUSY).
- One sub-module is natural: md_tracker, which holds the mult/div state machine and counter and outputs mdBusy. Forwarding and stall logic stay in the top module.

## Test plan
- add $t0 in M, sub using $t0 as rsE → forwardAE=10. Change so only W matches → forwardAE=01. writeReg=0 with regWrite=1 → forwardAE=00.
- lw $t1 in E with rtD=$t1 → stallF=stallD=flushE=1 for one cycle, stallCount increments from 0 to 1. The next cycle forwardBE=01.
- beq in Decode with rsD matching an ALU writer in M:
  - with the macro defined → forwardAD=1, no stall;
  - without the macro → stall.
  - Same case with a load in M → stall in both builds.
- MD_LATENCY=4: mdStartE pulse at cycle 0 and mfhi held in Decode → stallD high for cycles 1-4 and low at cycle 5; mdBusy follows the state machine.
- rst_n dropped during BUSY → mdBusy=0 immediately, stallCount=0. mfhi after release → no stall.
- pcSrcD=1 with loadStall=1 → flushD=0. Once the stall clears → flushD=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks: forwarding mux
// select encodings, mult/div tracker state type and the forward-select helper.
package mips_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // Memory stage wins over Writeback; $0 is hard-wired zero and never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       reg_write_m,
    input logic [4:0] write_reg_m,
    input logic       reg_write_w,
    input logic [4:0] write_reg_w
  );
    if (reg_write_m && (write_reg_m != 5'd0) && (write_reg_m == src))
      return FWD_MEM;
    else if (reg_write_w && (write_reg_w != 5'd0) && (write_reg_w == src))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_unit_md_tracker.sv
// Tracks an in-flight multi-cycle mult/div; mdBusy is high for MD_LATENCY
// cycles after issue in Execute. A reissue while busy restarts the count.
module md_tracker
  import mips_pkg::*;
#(
  parameter int MD_LATENCY = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mdStartE,
  output logic mdBusy
);

  localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY - 1);

  md_state_t  state_q;
  logic [3:0] cnt_q;
  logic       busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (mdStartE) begin
            state_q <= MD_BUSY;
            cnt_q   <= MD_LOAD;
            busy_q  <= 1'b1;
          end
        end
        MD_BUSY: begin
          if (mdStartE) begin
            cnt_q <= MD_LOAD;
          end else if (cnt_q == 4'd0) begin
            state_q <= MD_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= MD_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mdBusy = busy_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: forwarding selects, stall/flush and a saturating
// stall-cycle counter. HAZARD_BRANCH_FWD_EN enables Decode-stage branch forwarding.
module hazard_unit
  import mips_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic [4:0]       rsE,
  input  logic [4:0]       rtE,
  input  logic [4:0]       writeRegE,
  input  logic [4:0]       writeRegM,
  input  logic [4:0]       writeRegW,
  input  logic             regWriteE,
  input  logic             regWriteM,
  input  logic             regWriteW,
  input  logic             memToRegE,
  input  logic             memToRegM,
  input  logic             branchD,
  input  logic             pcSrcD,
  input  logic             jumpD,
  input  logic             mdOpD,
  input  logic             mfHiLoD,
  input  logic             mdStartE,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             forwardAD,
  output logic             forwardBD,
  output logic             stallF,
  output logic             stallD,
  output logic             flushD,
  output logic             flushE,
  output logic             mdBusy,
  output logic [CNT_W-1:0] stallCount
);

  logic load_stall, branch_stall, md_stall, stall;
  logic e_match, m_hit, m_match;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign forwardAE = fwd_sel(rsE, regWriteM, writeRegM, regWriteW, writeRegW);
  assign forwardBE = fwd_sel(rtE, regWriteM, writeRegM, regWriteW, writeRegW);

  assign load_stall = memToRegE && regWriteE && (writeRegE != 5'd0) &&
                      ((writeRegE == rsD) || (writeRegE == rtD));

  assign e_match = regWriteE && (writeRegE != 5'd0) &&
                   ((writeRegE == rsD) || (writeRegE == rtD));
  assign m_hit   = regWriteM && (writeRegM != 5'd0) &&
                   ((writeRegM == rsD) || (writeRegM == rtD));

`ifdef HAZARD_BRANCH_FWD_EN
  // ALU results in Memory reach the comparator directly; only loads must wait.
  assign m_match   = m_hit && memToRegM;
  assign forwardAD = regWriteM && (writeRegM != 5'd0) && (writeRegM == rsD);
  assign forwardBD = regWriteM && (writeRegM != 5'd0) && (writeRegM == rtD);
`else
  logic unused_mem_to_reg_m;
  assign unused_mem_to_reg_m = memToRegM;
  assign m_match   = m_hit;
  assign forwardAD = 1'b0;
  assign forwardBD = 1'b0;
`endif

  assign branch_stall = branchD && (e_match || m_match);
  assign md_stall     = mdBusy && (mfHiLoD || mdOpD);
  assign stall        = load_stall | branch_stall | md_stall;

  assign stallF = stall;
  assign stallD = stall;
  assign flushE = stall;
  assign flushD = (pcSrcD | jumpD) & ~stall;

  md_tracker #(
    .MD_LATENCY(MD_LATENCY)
  ) u_md_tracker (
    .clk     (clk),
    .rst_n   (rst_n),
    .mdStartE(mdStartE),
    .mdBusy  (mdBusy)
  );

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed and randomized check of hazard_unit against a behavioural model.
module tb_hazard_unit;

  localparam int LAT   = 4;
  localparam int CW    = 4;
  localparam int CSAT  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
  logic regWriteE, regWriteM, regWriteW, memToRegE, memToRegM;
  logic branchD, pcSrcD, jumpD, mdOpD, mfHiLoD, mdStartE;
  logic [1:0] forwardAE, forwardBE;
  logic forwardAD, forwardBD, stallF, stallD, flushD, flushE, mdBusy;
  logic [CW-1:0] stallCount;

  int total = 0;
  int bad = 0;

  int m_rem = 0;
  int m_cnt = 0;

  hazard_unit #(.MD_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
    .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
    .memToRegE(memToRegE), .memToRegM(memToRegM),
    .branchD(branchD), .pcSrcD(pcSrcD), .jumpD(jumpD),
    .mdOpD(mdOpD), .mfHiLoD(mfHiLoD), .mdStartE(mdStartE),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .mdBusy(mdBusy), .stallCount(stallCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int m_fwd(input int src);
    if (regWriteM && writeRegM != 0 && int'(writeRegM) == src) return 2;
    if (regWriteW && writeRegW != 0 && int'(writeRegW) == src) return 1;
    return 0;
  endfunction

  function automatic bit m_reads(input logic [4:0] r);
    return r != 0 && (r == rsD || r == rtD);
  endfunction

  function automatic bit m_stall();
    bit ld, br, md, mq;
    ld = memToRegE && regWriteE && m_reads(writeRegE);
`ifdef HAZARD_BRANCH_FWD_EN
    mq = regWriteM && memToRegM && m_reads(writeRegM);
`else
    mq = regWriteM && m_reads(writeRegM);
`endif
    br = branchD && ((regWriteE && m_reads(writeRegE)) || mq);
    md = (m_rem > 0) && (mfHiLoD || mdOpD);
    return ld || br || md;
  endfunction

  function automatic bit m_fwd_d(input logic [4:0] r);
`ifdef HAZARD_BRANCH_FWD_EN
    return regWriteM && writeRegM != 0 && writeRegM == r;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem = 0;
      m_cnt = 0;
    end else begin
      if (m_stall() && m_cnt < CSAT) m_cnt = m_cnt + 1;
      if (mdStartE) m_rem = LAT;
      else if (m_rem > 0) m_rem = m_rem - 1;
    end
  end

  always @(negedge clk) begin
    bit s;
    s = m_stall();
    chk("fwdAE", 32'(forwardAE), 32'(m_fwd(int'(rsE))));
    chk("fwdBE", 32'(forwardBE), 32'(m_fwd(int'(rtE))));
    chk("fwdAD", 32'(forwardAD), 32'(m_fwd_d(rsD)));
    chk("fwdBD", 32'(forwardBD), 32'(m_fwd_d(rtD)));
    chk("stallF", 32'(stallF), 32'(s));
    chk("stallD", 32'(stallD), 32'(s));
    chk("flushE", 32'(flushE), 32'(s));
    chk("flushD", 32'(flushD), 32'((pcSrcD || jumpD) && !s));
    chk("mdBusy", 32'(mdBusy), 32'(m_rem > 0));
    chk("stallCount", 32'(stallCount), 32'(m_cnt));
  end

  // ---------------- stimulus ----------------
  task automatic clr();
    {rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW} = '0;
    {regWriteE, regWriteM, regWriteW, memToRegE, memToRegM} = '0;
    {branchD, pcSrcD, jumpD, mdOpD, mfHiLoD, mdStartE} = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  initial begin
    clr();
    at_neg();
    chk("rst_busy", 32'(mdBusy), 32'd0);
    chk("rst_cnt", 32'(stallCount), 32'd0);
    step();
    rst_n = 1'b1;

    // Forwarding priority and $0
    step(); clr();
    regWriteM = 1; writeRegM = 5'd8; regWriteW = 1; writeRegW = 5'd8; rsE = 5'd8;
    at_neg(); chk("fwd_mem", 32'(forwardAE), 32'd2);
    step(); regWriteM = 0;
    at_neg(); chk("fwd_wb", 32'(forwardAE), 32'd1);
    step(); regWriteM = 1; writeRegM = 5'd0; writeRegW = 5'd0; rsE = 5'd0;
    at_neg(); chk("fwd_zero", 32'(forwardAE), 32'd0);

    // Load-use: one stall cycle then WB forwarding
    step(); clr();
    memToRegE = 1; regWriteE = 1; writeRegE = 5'd9; rtD = 5'd9;
    at_neg();
    chk("ld_stallF", 32'(stallF), 32'd1);
    chk("ld_stallD", 32'(stallD), 32'd1);
    chk("ld_flushE", 32'(flushE), 32'd1);
    chk("ld_cnt0", 32'(stallCount), 32'd0);
    step(); clr();
    regWriteM = 1; memToRegM = 1; writeRegM = 5'd9; rtD = 5'd9;
    at_neg();
    chk("ld_released", 32'(stallD), 32'd0);
    chk("ld_cnt1", 32'(stallCount), 32'd1);
    step(); clr();
    regWriteW = 1; writeRegW = 5'd9; rtE = 5'd9;
    at_neg(); chk("ld_fwdBE", 32'(forwardBE), 32'd1);

    // Branch against an ALU result, then a load, in Memory
    step(); clr();
    branchD = 1; rsD = 5'd10; regWriteM = 1; writeRegM = 5'd10;
    at_neg();
`ifdef HAZARD_BRANCH_FWD_EN
    chk("br_fwdAD", 32'(forwardAD), 32'd1);
    chk("br_alu_stall", 32'(stallD), 32'd0);
`else
    chk("br_fwdAD", 32'(forwardAD), 32'd0);
    chk("br_alu_stall", 32'(stallD), 32'd1);
`endif
    step(); memToRegM = 1;
    at_neg(); chk("br_ld_stall", 32'(stallD), 32'd1);

    // mfhi behind a mult issued at cycle 0
    step(); clr();
    mdStartE = 1; mfHiLoD = 1;
    for (int i = 0; i <= 5; i++) begin
      at_neg();
      chk($sformatf("md_stall_c%0d", i), 32'(stallD), 32'((i >= 1 && i <= 4)));
      chk($sformatf("md_busy_c%0d", i), 32'(mdBusy), 32'((i >= 1 && i <= 4)));
      step(); mdStartE = 0;
    end

    // Reset in the middle of a mult/div
    clr(); mdStartE = 1;
    step(); mdStartE = 0;
    step(); mfHiLoD = 1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(mdBusy), 32'd0);
    chk("rst_mid_cnt", 32'(stallCount), 32'd0);
    step(); rst_n = 1'b1;
    at_neg(); chk("post_rst_mfhi", 32'(stallD), 32'd0);

    // Taken branch loses to a load stall
    step(); clr();
    pcSrcD = 1; memToRegE = 1; regWriteE = 1; writeRegE = 5'd3; rsD = 5'd3;
    at_neg(); chk("flushD_stalled", 32'(flushD), 32'd0);
    step(); memToRegE = 0; regWriteE = 0;
    at_neg(); chk("flushD_taken", 32'(flushD), 32'd1);

    // Randomized traffic; the per-cycle compare process does the checking
    for (int n = 0; n < 3000; n++) begin
      step();
      rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
      rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
      writeRegE = 5'($urandom_range(0, 3));
      writeRegM = 5'($urandom_range(0, 3));
      writeRegW = 5'($urandom_range(0, 3));
      regWriteE = 1'($urandom); regWriteM = 1'($urandom); regWriteW = 1'($urandom);
      memToRegE = 1'($urandom); memToRegM = 1'($urandom);
      branchD = 1'($urandom); pcSrcD = 1'($urandom); jumpD = ($urandom_range(0, 3) == 0);
      mdOpD = ($urandom_range(0, 3) == 0); mfHiLoD = ($urandom_range(0, 3) == 0);
      mdStartE = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
      end
    end

    step(); clr();
    at_neg();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
